ring_ctrl: RTL and testbench

RING_CTRL -- requirements
Module: ring_ctrl

---
 rtl/ring_pkg.sv | 23 ++
 rtl/ring_ctrl_ack_sync.sv | 18 +
 rtl/ring_ctrl.sv | 125 ++++++++++++
 tb/tb_ring_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared types and default sizing for the ring-oscillator measurement controller.
package ring_pkg;

  localparam int WIN_W_DEF      = 16;
  localparam int CNT_W_DEF      = 24;
  localparam int RST_CYC_DEF    = 8;
  localparam int SETTLE_CYC_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_SETTLE,
    ST_MEASURE,
    ST_DONE
  } ring_ctrl_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ring_ctrl_ack_sync.sv
// Two-flop synchronizer bringing the asynchronous ring tap into the clk domain.
module ack_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/ring_ctrl.sv
// Runs one ring-oscillator measurement: hold ring in reset, let it settle,
// then count synchronized rising edges of the tap over a window of win_len cycles.
module ring_ctrl
  import ring_pkg::*;
#(
  parameter int WIN_W      = WIN_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int RST_CYC    = RST_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ring_ack,
  output logic             ring_rst,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam int CYC_W = max3(WIN_W, $clog2(RST_CYC + 1), $clog2(SETTLE_CYC + 1));
  localparam logic [CYC_W-1:0] RST_LAST    = CYC_W'(RST_CYC - 1);
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);

  ring_ctrl_state_t state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             ack_s, delay_q;
  logic             rise;
  logic [CYC_W-1:0] win_last;

  ack_sync u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ring_ack),
    .q_o   (ack_s)
  );

  assign rise     = ack_s & ~delay_q;
  assign win_last = CYC_W'(win_q) - CYC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      win_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      delay_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      win_q   <= win_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      delay_q <= ack_s;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    win_d   = win_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_RESET;
          cyc_d   = '0;
          win_d   = win_len;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_RESET: begin
        if (cyc_q == RST_LAST) begin
          state_d = ST_SETTLE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cyc_q == SETTLE_LAST) begin
          // A zero-length window skips measurement entirely.
          state_d = (win_q == '0) ? ST_DONE : ST_MEASURE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          if (&count_q) ovf_d = 1'b1;
          else          count_d = count_q + CNT_W'(1);
        end
        if (cyc_q == win_last) begin
          state_d = ST_DONE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cyc_d   = '0;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign ring_rst = (state_q == ST_IDLE) || (state_q == ST_RESET) || (state_q == ST_DONE);
  assign count    = count_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_ring_ctrl.sv
// Directed bench for ring_ctrl: latency, edge counting, saturation, abort and reset.
module tb_ring_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] win_len = '0;
  logic        ring_ack = 1'b0;
  logic        ring_rst, busy, done, ovf;
  logic [23:0] count;
  logic        ring_rst4, busy4, done4, ovf4;
  logic [3:0]  count4;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int low_cnt = 0;
  int ack_half = 5;
  bit ack_en = 1'b0;

  ring_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .win_len(win_len),
    .ring_ack(ring_ack), .ring_rst(ring_rst), .busy(busy), .done(done),
    .count(count), .ovf(ovf)
  );

  ring_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .win_len(win_len),
    .ring_ack(ring_ack), .ring_rst(ring_rst4), .busy(busy4), .done(done4),
    .count(count4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  // Tap toggles every ack_half clk periods, phase-shifted off the clock edges.
  initial begin
    #3;
    forever begin
      #(ack_half * 10);
      ring_ack = ack_en ? ~ring_ack : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy && !ring_rst) low_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a run, scramble win_len after acceptance, and return the cycle done appears.
  task automatic run(input int w, input bit hold, output int lat);
    lat     = -1;
    win_len = 16'(w);
    start   = 1'b1;
    low_cnt = 0;
    for (int n = 1; n <= 1500; n++) begin
      tick();
      if (n == 1) begin
        start   = hold;
        win_len = 16'd5;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    tick();
  endtask

  initial begin
    int lat;
    int d0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ring_rst", ring_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    ack_en = 1'b1;
    tick();

    // Nominal window: 100 cycles, tap period 10 -> about 10 edges.
    ack_half = 5;
    d0 = done_cnt;
    run(100, 1'b0, lat);
    chk("w100_latency", lat, 173);
    chk("w100_count_range", (count >= 9 && count <= 11), 1);
    chk("w100_ovf", ovf, 0);
    chk("w100_ring_low_cycles", low_cnt, 164);
    chk("w100_one_done", done_cnt - d0, 1);
    chk("w100_idle_after", busy, 0);
    chk("w100_count_hold", (count >= 9 && count <= 11), 1);

    // Zero window skips MEASURE.
    run(0, 1'b0, lat);
    chk("w0_latency", lat, 73);
    chk("w0_count", count, 0);
    chk("w0_ring_low_cycles", low_cnt, 64);

    // Saturation: 200 cycles at period 8 -> 25 edges, 4-bit counter saturates.
    ack_half = 4;
    run(200, 1'b0, lat);
    chk("w200_latency", lat, 273);
    chk("w200_cnt4", count4, 15);
    chk("w200_ovf4", ovf4, 1);
    chk("w200_count24_range", (count >= 24 && count <= 26), 1);
    chk("w200_ovf24", ovf, 0);

    // Abort in the 20th cycle of MEASURE.
    ack_half = 5;
    d0 = done_cnt;
    win_len = 16'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (91) tick();
    chk("abort_busy_before", busy, 1);
    chk("abort_ring_rst_before", ring_rst, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ring_rst", ring_rst, 1);
    chk("abort_partial_count", (count >= 1 && count <= 3), 1);
    repeat (120) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_stays_idle", busy, 0);

    // Abort and start together in IDLE: nothing happens.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_idle", busy, 0);

    // Start held for the whole run is not queued as a second run.
    d0 = done_cnt;
    run(0, 1'b1, lat);
    chk("hold_latency", lat, 73);
    chk("hold_one_done", done_cnt - d0, 1);
    chk("hold_idle_after", busy, 0);

    // Reset mid-SETTLE, then a clean full run.
    d0 = done_cnt;
    win_len = 16'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    chk("rst_mid_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ring_rst", ring_rst, 1);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_ovf", ovf, 0);
    tick();
    rst_n = 1'b1;
    repeat (100) tick();
    chk("rst_mid_no_done", done_cnt - d0, 0);
    run(100, 1'b0, lat);
    chk("rst_rerun_latency", lat, 173);
    chk("rst_rerun_count_range", (count >= 9 && count <= 11), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
